// File: rtl/hci_streamer_job_sched_if.sv
// Descriptor push channel into the streamer job scheduler.
// Carries one {desc, id} job per valid & ready beat.
interface hci_streamer_job_sched_if #(
    parameter int unsigned DESC_WIDTH = 96,
    parameter int unsigned ID_WIDTH   = 4
);
    logic                  valid;
    logic                  ready;
    logic [DESC_WIDTH-1:0] desc;
    logic [ID_WIDTH-1:0]   id;

    modport master (output valid, output desc, output id, input ready);
    modport slave  (input valid, input desc, input id, output ready);
endinterface

// File: rtl/hci_streamer_job_sched.sv
// Sequences one HCI streamer through a FIFO of address-generation descriptors,
// launching each job, waiting for done and emitting a tagged completion event.
package hci_streamer_job_sched_pkg;
    typedef struct packed {
        logic [31:0] base_addr;
        logic [31:0] tot_len;
        logic [15:0] d0_len;
        logic [15:0] d0_stride;
    } hci_streamer_addressgen_ctrl_t;

    typedef struct packed {
        logic                          req_start;
        hci_streamer_addressgen_ctrl_t addressgen_ctrl;
    } hci_streamer_ctrl_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } hci_streamer_flags_t;
endpackage

module hci_streamer_job_sched
    import hci_streamer_job_sched_pkg::*;
#(
    parameter int unsigned NB_JOBS   = 4,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             abort_i,
    hci_streamer_job_sched_if.slave          push,
    output hci_streamer_ctrl_t               ctrl_o,
    input  hci_streamer_flags_t              flags_i,
    output logic                             stream_clear_o,
    output logic                             evt_done_o,
    output logic [ID_WIDTH-1:0]              evt_id_o,
    output logic                             busy_o,
    output logic [$clog2(NB_JOBS+1)-1:0]     queue_cnt_o,
    output logic [CNT_WIDTH-1:0]             jobs_done_o
);
    localparam int unsigned PTR_W  = (NB_JOBS > 1) ? $clog2(NB_JOBS) : 1;
    localparam int unsigned QCNT_W = $clog2(NB_JOBS + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_e;

    state_e                        state;
    logic [PTR_W-1:0]              wr_ptr, rd_ptr;
    logic [QCNT_W-1:0]             cnt;
    hci_streamer_addressgen_ctrl_t desc_mem [NB_JOBS];
    logic [ID_WIDTH-1:0]           id_mem   [NB_JOBS];
    hci_streamer_addressgen_ctrl_t act_desc;
    logic [ID_WIDTH-1:0]           act_id;
    logic                          do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NB_JOBS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // No bypass: a full queue refuses pushes even while popping.
    assign push.ready = (cnt != QCNT_W'(NB_JOBS)) && !abort_i && !clear_i;
    assign do_push    = push.valid && push.ready;
    assign do_pop     = (state == IDLE) && (cnt != '0) && flags_i.ready_start
                        && !abort_i && !clear_i;

    assign ctrl_o.req_start       = (state == LAUNCH);
    assign ctrl_o.addressgen_ctrl = act_desc;
    assign stream_clear_o         = clear_i | abort_i;
    assign busy_o                 = (state != IDLE) || (cnt != '0);
    assign queue_cnt_o            = cnt;

    // Queue storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            desc_mem[wr_ptr] <= hci_streamer_addressgen_ctrl_t'(push.desc);
            id_mem[wr_ptr]   <= ID_WIDTH'(push.id);
        end
    end

    // Scheduler FSM, queue pointers, event and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            act_desc    <= '0;
            act_id      <= '0;
            evt_done_o  <= 1'b0;
            evt_id_o    <= '0;
            jobs_done_o <= '0;
        end else if (clear_i) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            act_desc    <= '0;
            act_id      <= '0;
            evt_done_o  <= 1'b0;
            evt_id_o    <= '0;
            jobs_done_o <= '0;
        end else begin
            evt_done_o <= 1'b0;
            if (abort_i) begin
                // Abort overrides a coincident done: no event, no count.
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                state  <= IDLE;
            end else begin
                if (do_push) wr_ptr <= ptr_next(wr_ptr);
                if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
                case ({do_push, do_pop})
                    2'b10:   cnt <= cnt + QCNT_W'(1);
                    2'b01:   cnt <= cnt - QCNT_W'(1);
                    default: cnt <= cnt;
                endcase
                unique case (state)
                    IDLE: begin
                        if (do_pop) begin
                            act_desc <= desc_mem[rd_ptr];
                            act_id   <= id_mem[rd_ptr];
                            state    <= LAUNCH;
                        end
                    end
                    LAUNCH: state <= RUN;
                    RUN: begin
                        if (flags_i.done) begin
                            evt_done_o  <= 1'b1;
                            evt_id_o    <= act_id;
                            jobs_done_o <= jobs_done_o + CNT_WIDTH'(1);
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hci_streamer_job_sched.sv
// Bench for hci_streamer_job_sched: directed vector table, hand-written corner
// sequences and random traffic checked against a queue-based reference model.
module tb_hci_streamer_job_sched;
    import hci_streamer_job_sched_pkg::*;

    localparam int unsigned NB_JOBS   = 4;
    localparam int unsigned ID_WIDTH  = 4;
    localparam int unsigned CNT_WIDTH = 2;
    localparam int unsigned QW        = $clog2(NB_JOBS + 1);

    typedef logic [ID_WIDTH-1:0]   id_t;
    typedef hci_streamer_addressgen_ctrl_t desc_t;
    typedef struct { desc_t desc; id_t id; } job_t;
    typedef struct {
        int v, id, rs, dn, ab;
        int e_req, e_evt, e_eid, e_qc, e_busy, e_rdy, e_sclr, e_jobs;
    } vec_t;

    logic                 clk, rst_ni, clear_i, abort_i;
    hci_streamer_ctrl_t   ctrl_o;
    hci_streamer_flags_t  flags_i;
    logic                 stream_clear_o, evt_done_o, busy_o;
    id_t                  evt_id_o;
    logic [QW-1:0]        queue_cnt_o;
    logic [CNT_WIDTH-1:0] jobs_done_o;

    hci_streamer_job_sched_if #(.DESC_WIDTH($bits(desc_t)), .ID_WIDTH(ID_WIDTH)) push_if ();

    hci_streamer_job_sched #(
        .NB_JOBS(NB_JOBS), .ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .abort_i(abort_i),
        .push(push_if), .ctrl_o(ctrl_o), .flags_i(flags_i),
        .stream_clear_o(stream_clear_o), .evt_done_o(evt_done_o), .evt_id_o(evt_id_o),
        .busy_o(busy_o), .queue_cnt_o(queue_cnt_o), .jobs_done_o(jobs_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: job queue plus the job currently handed to the streamer.
    job_t  mq[$];
    bit    m_has_job, m_started, m_evt;
    desc_t m_act_desc;
    id_t   m_act_id, m_evt_id;
    int    m_jobs;

    vec_t tbl [15];

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_has_job = 0; m_started = 0; m_evt = 0;
        m_act_desc = '0; m_act_id = '0; m_evt_id = '0; m_jobs = 0;
    endfunction

    function automatic desc_t rand_desc();
        desc_t d;
        d.base_addr = $urandom;
        d.tot_len   = $urandom;
        d.d0_len    = 16'($urandom);
        d.d0_stride = 16'($urandom);
        return d;
    endfunction

    function automatic void compare_model();
        check("push_ready",   128'(push_if.ready),
              128'((mq.size() < NB_JOBS) && !abort_i && !clear_i));
        check("stream_clear", 128'(stream_clear_o), 128'(clear_i | abort_i));
        check("req_start",    128'(ctrl_o.req_start), 128'(m_has_job && !m_started));
        check("desc",         128'(ctrl_o.addressgen_ctrl), 128'(m_act_desc));
        check("evt_done",     128'(evt_done_o), 128'(m_evt));
        if (m_evt) check("evt_id", 128'(evt_id_o), 128'(m_evt_id));
        check("queue_cnt",    128'(queue_cnt_o), 128'(mq.size()));
        check("busy",         128'(busy_o), 128'(m_has_job || (mq.size() != 0)));
        check("jobs_done",    128'(jobs_done_o), 128'(m_jobs));
    endfunction

    function automatic void model_step();
        bit acc, pop;
        job_t j;
        acc = push_if.valid && (mq.size() < NB_JOBS) && !abort_i && !clear_i;
        if (clear_i) begin
            m_reset();
            return;
        end
        m_evt = 0;
        if (abort_i) begin
            mq.delete();
            m_has_job = 0;
            m_started = 0;
            return;
        end
        pop = !m_has_job && (mq.size() != 0) && flags_i.ready_start;
        if (m_has_job && !m_started) m_started = 1;
        else if (m_has_job && m_started && flags_i.done) begin
            m_evt = 1;
            m_evt_id = m_act_id;
            m_jobs = (m_jobs + 1) % (1 << CNT_WIDTH);
            m_has_job = 0;
        end
        if (pop) begin
            j = mq.pop_front();
            m_act_desc = j.desc;
            m_act_id = j.id;
            m_has_job = 1;
            m_started = 0;
        end
        if (acc) begin
            j.desc = push_if.desc;
            j.id = push_if.id;
            mq.push_back(j);
        end
    endfunction

    // Called at a falling edge with inputs applied; crosses one rising edge.
    task automatic tick();
        #1;
        compare_model();
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input int v, input int id, input int rs, input int dn, input int ab);
        push_if.valid       = (v != 0);
        push_if.id          = id_t'(id);
        push_if.desc        = rand_desc();
        flags_i.ready_start = (rs != 0);
        flags_i.done        = (dn != 0);
        abort_i             = (ab != 0);
        clear_i             = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"},   128'(ctrl_o.req_start), 128'(0));
        check({tag, "_desc"},  128'(ctrl_o.addressgen_ctrl), 128'(0));
        check({tag, "_evt"},   128'(evt_done_o), 128'(0));
        check({tag, "_evtid"}, 128'(evt_id_o), 128'(0));
        check({tag, "_jobs"},  128'(jobs_done_o), 128'(0));
        check({tag, "_qcnt"},  128'(queue_cnt_o), 128'(0));
        check({tag, "_busy"},  128'(busy_o), 128'(0));
        check({tag, "_ready"}, 128'(push_if.ready), 128'(1));
        check({tag, "_sclr"},  128'(stream_clear_o), 128'(0));
    endtask

    // Leaves the caller at the req_start cycle (not yet ticked) when found.
    task automatic wait_req(output bit found);
        found = 0;
        for (int w = 0; w < 40; w++) begin
            drive(0, 0, 1, 0, 0);
            #1;
            if (ctrl_o.req_start) begin
                found = 1;
                break;
            end
            tick();
        end
        check("req_seen", 128'(found), 128'(1));
    endtask

    // Runs the next job for len cycles after req_start, ends at its event cycle.
    task automatic run_job(input int id, input int len, output int req_cyc, output int done_cyc);
        bit found;
        req_cyc = -1;
        done_cyc = -1;
        wait_req(found);
        if (found) begin
            req_cyc = cyc;
            tick();
            repeat (len - 1) begin
                drive(0, 0, 1, 0, 0);
                tick();
            end
            drive(0, 0, 1, 1, 0);
            done_cyc = cyc;
            tick();
            drive(0, 0, 1, 0, 0);
            #1;
            check("job_evt", 128'(evt_done_o), 128'(1));
            check("job_id",  128'(evt_id_o), 128'(id));
        end
    endtask

    initial begin
        bit found;
        int rq, dn, prev_dn;

        //         v id rs dn ab | req evt eid qc busy rdy sclr jobs
        tbl = '{
            '{1, 3, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0},
            '{0, 0, 1, 0, 0,   0, 0, 0, 1, 1, 1, 0, 0},
            '{0, 0, 1, 0, 0,   1, 0, 0, 0, 1, 1, 0, 0},
            '{0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 1, 0, 0},
            '{0, 0, 1, 0, 0,   0, 0, 0, 0, 1, 1, 0, 0},
            '{0, 0, 1, 1, 0,   0, 0, 0, 0, 1, 1, 0, 0},
            '{0, 0, 0, 0, 0,   0, 1, 3, 0, 0, 1, 0, 1},
            '{1, 4, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 1},
            '{1, 5, 0, 0, 0,   0, 0, 0, 1, 1, 1, 0, 1},
            '{1, 6, 0, 0, 0,   0, 0, 0, 2, 1, 1, 0, 1},
            '{1, 7, 0, 0, 0,   0, 0, 0, 3, 1, 1, 0, 1},
            '{1, 8, 0, 0, 0,   0, 0, 0, 4, 1, 0, 0, 1},
            '{0, 0, 0, 0, 0,   0, 0, 0, 4, 1, 0, 0, 1},
            '{0, 0, 0, 0, 1,   0, 0, 0, 4, 1, 0, 1, 1},
            '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 1}
        };

        m_reset();
        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rst_ni = 1'b1;

        // Single job, queue fill, abort flush.
        for (int i = 0; i < $size(tbl); i++) begin
            drive(tbl[i].v, tbl[i].id, tbl[i].rs, tbl[i].dn, tbl[i].ab);
            #1;
            check("t_req",   128'(ctrl_o.req_start), 128'(tbl[i].e_req));
            check("t_evt",   128'(evt_done_o), 128'(tbl[i].e_evt));
            if (tbl[i].e_evt != 0) check("t_evtid", 128'(evt_id_o), 128'(tbl[i].e_eid));
            check("t_qcnt",  128'(queue_cnt_o), 128'(tbl[i].e_qc));
            check("t_busy",  128'(busy_o), 128'(tbl[i].e_busy));
            check("t_ready", 128'(push_if.ready), 128'(tbl[i].e_rdy));
            check("t_sclr",  128'(stream_clear_o), 128'(tbl[i].e_sclr));
            check("t_jobs",  128'(jobs_done_o), 128'(tbl[i].e_jobs));
            tick();
        end

        // Back-to-back jobs 1, 2, 3 with done 10 cycles after each req_start.
        for (int k = 1; k <= 3; k++) begin
            drive(1, k, 0, 0, 0);
            tick();
        end
        prev_dn = -1;
        for (int k = 1; k <= 3; k++) begin
            run_job(k, 10, rq, dn);
            if (prev_dn >= 0) check("b2b_gap", 128'(rq - prev_dn), 128'(2));
            prev_dn = dn;
        end
        check("b2b_jobs_wrap", 128'(jobs_done_o), 128'(0));
        tick();

        // Fifth completed job: counter wraps to 1.
        drive(1, 5, 1, 0, 0);
        tick();
        run_job(5, 4, rq, dn);
        check("wrap_jobs", 128'(jobs_done_o), 128'(1));
        tick();

        // Abort during RUN with a second job queued.
        drive(1, 9, 0, 0, 0);
        tick();
        drive(1, 10, 0, 0, 0);
        tick();
        wait_req(found);
        tick();
        repeat (3) begin
            drive(0, 0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 1, 0, 1);
        #1;
        check("abort_sclr",  128'(stream_clear_o), 128'(1));
        check("abort_ready", 128'(push_if.ready), 128'(0));
        tick();
        drive(0, 0, 1, 0, 0);
        #1;
        check("abort_qcnt", 128'(queue_cnt_o), 128'(0));
        check("abort_busy", 128'(busy_o), 128'(0));
        check("abort_evt",  128'(evt_done_o), 128'(0));
        check("abort_jobs", 128'(jobs_done_o), 128'(1));
        check("abort_sclr_off", 128'(stream_clear_o), 128'(0));
        tick();
        drive(0, 0, 1, 1, 0);
        tick();
        drive(0, 0, 1, 0, 0);
        tick();

        // Abort and done in the same cycle.
        drive(1, 11, 1, 0, 0);
        tick();
        wait_req(found);
        tick();
        repeat (2) begin
            drive(0, 0, 1, 0, 0);
            tick();
        end
        drive(0, 0, 1, 1, 1);
        tick();
        drive(0, 0, 1, 0, 0);
        #1;
        check("coll_evt",  128'(evt_done_o), 128'(0));
        check("coll_jobs", 128'(jobs_done_o), 128'(1));
        check("coll_busy", 128'(busy_o), 128'(0));
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 2) != 0) ? 1 : 0, int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  ($urandom_range(0, 5) == 0) ? 1 : 0,
                  ($urandom_range(0, 59) == 0) ? 1 : 0);
            clear_i = ($urandom_range(0, 99) == 0);
            tick();
        end

        // Asynchronous reset in the middle of a job.
        drive(0, 0, 0, 0, 1);
        tick();
        drive(1, 12, 1, 0, 0);
        tick();
        wait_req(found);
        tick();
        drive(1, 13, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        #1;
        check_reset("rst_mid_run");
        m_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hci_streamer_job_sched.md
# hci_streamer_job_sched

Job scheduler that sequences one HCI source/sink streamer through a queue of address-generation descriptors. Software or a register file pushes descriptors into an internal FIFO. The scheduler launches each job on the streamer's control plane, waits for the streamer's `done`, and then raises a completion event tagged with the job ID. It sits between the HWPE register file / controller and the `ctrl_i`/`flags_o` ports of a streamer, so multi-job transfers run without controller intervention.

## Interface
- `NB_JOBS`, default 4: descriptor queue depth, ≥ 2.
- `ID_WIDTH`, default 4: width of the job tag.
- `CNT_WIDTH`, default 16: width of the completed-jobs counter.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous clear. Same effect as reset, applied in-cycle.
- `abort_i`  in  1  abort current job and flush the queue.
- `push_valid_i`  in  1  descriptor valid.
- `push_ready_o`  out  1  queue can accept a descriptor.
- `push_desc_i`  in  addressgen_ctrl field of `hci_streamer_ctrl_t`  job descriptor.
- `push_id_i`  in  `ID_WIDTH`  job tag.
- `ctrl_o`  out  `hci_streamer_ctrl_t`  drives streamer `ctrl_i`.
- `flags_i`  in  `hci_streamer_flags_t`  from streamer `flags_o`. Uses `ready_start` and `done`.
- `stream_clear_o`  out  1  drives streamer `clear_i`.
- `evt_done_o`  out  1  one-cycle job-completion pulse.
- `evt_id_o`  out  `ID_WIDTH`  tag of the completed job. Valid while `evt_done_o` is high.
- `busy_o`  out  1  a job is active, or the queue is non-empty.
- `queue_cnt_o`  out  `$clog2(NB_JOBS+1)`  queued descriptor count, excluding the active job.
- `jobs_done_o`  out  `CNT_WIDTH`  completed-jobs counter.

## Operation
- **Queue**
  - Circular FIFO of {desc, id}, with `NB_JOBS` entries.
  - A push happens on `push_valid_i & push_ready_o`.
  - `push_ready_o = !full`. There is no bypass: a push to a full queue is refused, even in a pop cycle.
- **States:** IDLE, LAUNCH, RUN.
- **IDLE**
  - If the queue is non-empty and `flags_i.ready_start` is high: pop the head into the active registers (`act_desc`, `act_id`), then go to LAUNCH.
  - Otherwise stay in IDLE.
- **LAUNCH**
  - Drive `ctrl_o.req_start = 1` for exactly this cycle, with `ctrl_o.addressgen_ctrl = act_desc`.
  - Go to RUN.
- **RUN**
  - `ctrl_o.addressgen_ctrl` stays `act_desc`. `req_start = 0`.
  - On `flags_i.done`: register `evt_done_o = 1` and `evt_id_o = act_id` for the next cycle, increment `jobs_done_o`, then go to IDLE.
- `ctrl_o.addressgen_ctrl` always equals `act_desc`. Outside LAUNCH, `ctrl_o.req_start = 0`.
- **Abort** (`abort_i`, any state), in the same cycle:
  - Flush the queue, so `queue_cnt_o` reads 0 next cycle.
  - Force the FSM to IDLE.
  - Pulse `stream_clear_o` for 1 cycle.
  - Emit no `evt_done_o` and leave `jobs_done_o` unchanged.
  - A push presented in the abort cycle is dropped, and `push_ready_o` is forced to 0 in that cycle.
- **Abort and done in the same cycle:** abort wins. No event is raised and the counter is not incremented.
- **Counter:** `jobs_done_o` wraps modulo 2^`CNT_WIDTH`. Only reset or `clear_i` zeroes it.
- **`busy_o`:** equals `(state != IDLE) | (queue_cnt_o != 0)`.
- **`stream_clear_o`:** equals `clear_i | abort_pulse`.

## Timing
- **Reset values:**
  - FSM = IDLE; queue empty; `act_desc` = 0; `act_id` = 0.
  - `ctrl_o` = 0; `evt_done_o` = 0; `evt_id_o` = 0; `jobs_done_o` = 0; `queue_cnt_o` = 0; `busy_o` = 0.
  - `push_ready_o` = 1; `stream_clear_o` = 0.
- **Push-to-launch latency:**
  - Push accepted in cycle t into an empty queue, with the streamer ready.
  - Pop at t+1; `req_start` at t+2.
- **Done-to-event latency:** `flags_i.done` in cycle t gives `evt_done_o` at t+1.
- **Back-to-back jobs:**
  - `done` at t gives IDLE at t+1.
  - If `ready_start` is high at t+1, the next pop happens at t+1 and the next `req_start` at t+2.
  - There is a 2-cycle gap between `done` and the next `req_start`.
- **Descriptor stability:** `act_desc` is stable from the LAUNCH cycle until the next pop. The streamer presamples on `req_start` and uses the descriptor throughout the job.
- **Queue count on a simultaneous push and pop:** `queue_cnt_o` is unchanged.

## Test plan
- **Single job:** push id=3 at cycle 0.
  - `req_start` is high only at cycle 2, with desc equal to the pushed descriptor.
  - Streamer `done` at 20 gives `evt_done_o = 1` and `evt_id_o = 3` at 21, and `jobs_done_o = 1`.
- **Queue fill:** push 5 descriptors back-to-back with `ready_start = 0` and `NB_JOBS = 4`.
  - The first 4 are accepted; `push_ready_o = 0` on the 5th; `queue_cnt_o = 4`; `busy_o = 1`.
- **Back-to-back jobs:** queue ids 1, 2 and 3 with `done` 10 cycles after each `req_start`.
  - Events arrive in order 1, 2, 3; each `req_start` comes 2 cycles after the previous `done`; `jobs_done_o = 3`.
- **Abort mid-RUN:** 2 jobs queued, abort asserted during the first job's RUN.
  - `stream_clear_o` pulses once; `queue_cnt_o = 0`; no event; `jobs_done_o` unchanged; FSM is in IDLE.
- **Abort/done collision:** `abort_i` and `done` in the same cycle.
  - No `evt_done_o`; the counter is not incremented.
- **Counter wrap and reset:** with `CNT_WIDTH = 2`, complete 5 jobs, then assert `rst_ni` low mid-RUN.
  - `jobs_done_o = 1` after the 5th job.
  - After the reset, all outputs are at their reset values and `push_ready_o = 1`.
